// File: rtl/kernel_stream_collector.sv
// Leaf-stream sink: FIFO-buffers kernel words (1-cycle push-to-dout), up_ready drops SKID slots early, downstream valid/ready drain.
// Optional COLLECTOR_CHECKSUM_EN adds a running modulo-2^STREAMW sum of accepted words on checksum.
module kernel_stream_collector #(
    parameter int STREAMW = 32,
    parameter int DEPTH   = 16,
    parameter int SKID    = 2,
    parameter int CNTW    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNTW-1:0]    nwords,
    input  logic               ivalid,
    input  logic [STREAMW-1:0] in_data,
    output logic               up_ready,
    output logic [STREAMW-1:0] dout,
    output logic               dvalid,
    input  logic               dready,
    output logic [CNTW-1:0]    words_rcvd,
    output logic               done,
`ifdef COLLECTOR_CHECKSUM_EN
    output logic [STREAMW-1:0] checksum,
`endif
    output logic               overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] HI_WATER = (AW+1)'(DEPTH - SKID);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNTW-1:0]     nwords_q, words_rcvd_q;
    logic [AW:0]         count_q;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [STREAMW-1:0]  mem_q [DEPTH];
    logic                up_ready_q, overflow_q;
    logic                start_ok, want_word, push, drop, pop;
`ifdef COLLECTOR_CHECKSUM_EN
    logic [STREAMW-1:0]  checksum_q;
`endif

    assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign want_word = ivalid && (state_q == S_RUN) && (words_rcvd_q < nwords_q);
    // Full is judged on the registered count, so a same-cycle pop never rescues a push.
    assign push      = want_word && (count_q != FULL_CNT);
    assign drop      = want_word && (count_q == FULL_CNT);
    assign pop       = dvalid && dready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_ok) state_d = (nwords == '0) ? S_FLUSH : S_RUN;
            S_RUN:          if (words_rcvd_q == nwords_q) state_d = S_FLUSH;
            S_FLUSH:        if (count_q == '0) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dvalid = (count_q != '0);
        done   = (state_q == S_DONE);
        dout   = dvalid ? mem_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nwords_q     <= '0;
            words_rcvd_q <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            up_ready_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                nwords_q     <= nwords;
                words_rcvd_q <= '0;
                overflow_q   <= 1'b0;
            end else begin
                if (push) words_rcvd_q <= words_rcvd_q + CNTW'(1);
                if (drop) overflow_q   <= 1'b1;
            end
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            up_ready_q <= (state_q == S_RUN) && (count_q < HI_WATER) && (words_rcvd_q < nwords_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef COLLECTOR_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)           checksum_q <= '0;
        else if (start_ok) checksum_q <= '0;
        else if (push)     checksum_q <= checksum_q + in_data;
    end
    assign checksum = checksum_q;
`endif

    assign up_ready   = up_ready_q;
    assign words_rcvd = words_rcvd_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_kernel_stream_collector.sv
// Directed bench for kernel_stream_collector (DEPTH=16, SKID=2); inputs driven and outputs sampled on the falling edge.
module tb_kernel_stream_collector;

    localparam int W  = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst, start, ivalid, dready;
    logic [CW-1:0] nwords;
    logic [W-1:0]  in_data;
    logic          up_ready, dvalid, done, overflow;
    logic [W-1:0]  dout;
    logic [CW-1:0] words_rcvd;
`ifdef COLLECTOR_CHECKSUM_EN
    logic [W-1:0]  checksum;
`endif

    int nvec = 0;
    int nerr = 0;
    logic [W-1:0] got [$];

    kernel_stream_collector #(.STREAMW(W), .DEPTH(16), .SKID(2), .CNTW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .nwords     (nwords),
        .ivalid     (ivalid),
        .in_data    (in_data),
        .up_ready   (up_ready),
        .dout       (dout),
        .dvalid     (dvalid),
        .dready     (dready),
        .words_rcvd (words_rcvd),
        .done       (done),
`ifdef COLLECTOR_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus; records the word popped at the coming rising edge.
    task automatic tick(input logic st, input logic iv, input logic [W-1:0] d, input logic dr);
        @(negedge clk);
        start = st; ivalid = iv; in_data = d; dready = dr;
        if (dvalid && dready) got.push_back(dout);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; ivalid = 1'b0; dready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ivalid = 1'b0; dready = 1'b0; nwords = '0; in_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nvec++; if (up_ready !== 1'b0)  begin nerr++; $display("FAIL reset_up_ready: got %b want 0", up_ready); end
        nvec++; if (dvalid !== 1'b0)    begin nerr++; $display("FAIL reset_dvalid: got %b want 0", dvalid); end
        nvec++; if (done !== 1'b0)      begin nerr++; $display("FAIL reset_done: got %b want 0", done); end
        nvec++; if (overflow !== 1'b0)  begin nerr++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        nvec++; if (words_rcvd !== '0)  begin nerr++; $display("FAIL reset_words_rcvd: got %0d want 0", words_rcvd); end
        nvec++; if (dout !== '0)        begin nerr++; $display("FAIL reset_dout: got %0d want 0", dout); end
    endtask

    task automatic test_basic_frame();
        int n = 0;
        got.delete();
        nwords = 8;
        tick(1'b1, 1'b0, '0, 1'b1);
        for (int i = 1; i <= 8; i++) tick(1'b0, 1'b1, W'(i), 1'b1);
        while (!done && n < 30) begin tick(1'b0, 1'b0, '0, 1'b1); n++; end
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL basic_done: got %b want 1", done); end
        nvec++; if (got.size() != 8) begin nerr++; $display("FAIL basic_count: got %0d words want 8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if (i >= got.size() || got[i] !== W'(i + 1)) begin
                nerr++; $display("FAIL basic_word%0d: got %0d want %0d", i, (i < got.size()) ? got[i] : '0, i + 1);
            end
        end
        nvec++; if (words_rcvd !== 32'd8) begin nerr++; $display("FAIL basic_words_rcvd: got %0d want 8", words_rcvd); end
        nvec++; if (overflow !== 1'b0)    begin nerr++; $display("FAIL basic_overflow: got %b want 0", overflow); end
        nvec++; if (dvalid !== 1'b0)      begin nerr++; $display("FAIL basic_dvalid: got %b want 0", dvalid); end
`ifdef COLLECTOR_CHECKSUM_EN
        nvec++; if (checksum !== 32'd36)  begin nerr++; $display("FAIL basic_checksum: got %0d want 36", checksum); end
`endif
    endtask

    task automatic test_skid_overflow();
        logic exp_ur, exp_ov;
        got.delete();
        nwords = 32;
        tick(1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 1'b1, W'(100 + k), 1'b0);
            exp_ur = (k >= 1) && (k <= 14);
            exp_ov = (k >= 17);
            nvec++; if (up_ready !== exp_ur) begin nerr++; $display("FAIL skid_up_ready@%0d: got %b want %b", k, up_ready, exp_ur); end
            nvec++; if (overflow !== exp_ov) begin nerr++; $display("FAIL skid_overflow@%0d: got %b want %b", k, overflow, exp_ov); end
        end
        tick(1'b0, 1'b0, '0, 1'b0);
        nvec++; if (words_rcvd !== 32'd16) begin nerr++; $display("FAIL skid_words_rcvd: got %0d want 16", words_rcvd); end
        nvec++; if (overflow !== 1'b1)     begin nerr++; $display("FAIL skid_overflow_sticky: got %b want 1", overflow); end
        nvec++; if (dout !== 32'd100)      begin nerr++; $display("FAIL skid_head: got %0d want 100", dout); end
        repeat (20) tick(1'b0, 1'b0, '0, 1'b1);
        nvec++; if (got.size() != 16) begin nerr++; $display("FAIL skid_drain_count: got %0d want 16", got.size()); end
        for (int i = 0; i < 16; i++) begin
            nvec++;
            if (i >= got.size() || got[i] !== W'(100 + i)) begin
                nerr++; $display("FAIL skid_word%0d: got %0d want %0d", i, (i < got.size()) ? got[i] : '0, 100 + i);
            end
        end
        pulse_reset();
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL skid_reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_kernel_chain();
        logic         pend_v = 1'b0;
        logic [W-1:0] pend_d = '0;
        int           sent = 0;
        int           cyc = 0;
        got.delete();
        nwords = 12;
        tick(1'b1, 1'b0, '0, 1'b0);
        while (!done && cyc < 200) begin
            @(negedge clk);
            start = 1'b0; dready = cyc[0]; ivalid = pend_v; in_data = pend_d;
            if (dvalid && dready) got.push_back(dout);
            // The kernel registers whatever the source offered while up_ready was high.
            if (up_ready && sent < 12) begin pend_v = 1'b1; pend_d = W'(200 + sent); sent++; end
            else pend_v = 1'b0;
            cyc++;
        end
        nvec++; if (done !== 1'b1)         begin nerr++; $display("FAIL chain_done: got %b want 1", done); end
        nvec++; if (overflow !== 1'b0)     begin nerr++; $display("FAIL chain_overflow: got %b want 0", overflow); end
        nvec++; if (words_rcvd !== 32'd12) begin nerr++; $display("FAIL chain_words_rcvd: got %0d want 12", words_rcvd); end
        nvec++; if (got.size() != 12)      begin nerr++; $display("FAIL chain_count: got %0d want 12", got.size()); end
        for (int i = 0; i < 12; i++) begin
            nvec++;
            if (i >= got.size() || got[i] !== W'(200 + i)) begin
                nerr++; $display("FAIL chain_word%0d: got %0d want %0d", i, (i < got.size()) ? got[i] : '0, 200 + i);
            end
        end
    endtask

    task automatic test_zero_words();
        logic seen_dv = 1'b0;
        int   done_at = -1;
        nwords = 0;
        tick(1'b1, 1'b0, '0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b0, '0, 1'b1);
            if (dvalid) seen_dv = 1'b1;
            if (done && done_at < 0) done_at = k;
        end
        nvec++; if (done_at < 0 || done_at > 1) begin nerr++; $display("FAIL zero_done_latency: got %0d want 0..1", done_at); end
        nvec++; if (seen_dv !== 1'b0)   begin nerr++; $display("FAIL zero_dvalid: got %b want 0", seen_dv); end
        nvec++; if (words_rcvd !== '0)  begin nerr++; $display("FAIL zero_words_rcvd: got %0d want 0", words_rcvd); end
    endtask

    task automatic test_reset_mid_frame();
        nwords = 4;
        tick(1'b1, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b1, 32'd1, 1'b0);
        tick(1'b0, 1'b1, 32'd2, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0);
        nvec++; if (words_rcvd !== 32'd2) begin nerr++; $display("FAIL mid_pre_words: got %0d want 2", words_rcvd); end
        pulse_reset();
        nvec++; if (up_ready !== 1'b0)  begin nerr++; $display("FAIL mid_up_ready: got %b want 0", up_ready); end
        nvec++; if (dvalid !== 1'b0)    begin nerr++; $display("FAIL mid_dvalid: got %b want 0", dvalid); end
        nvec++; if (dout !== '0)        begin nerr++; $display("FAIL mid_dout: got %0d want 0", dout); end
        nvec++; if (words_rcvd !== '0)  begin nerr++; $display("FAIL mid_words_rcvd: got %0d want 0", words_rcvd); end
        nvec++; if (done !== 1'b0)      begin nerr++; $display("FAIL mid_done: got %b want 0", done); end
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, W'(9 + k), 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0);
        nvec++; if (words_rcvd !== '0)  begin nerr++; $display("FAIL mid_ignored_words: got %0d want 0", words_rcvd); end
        nvec++; if (dvalid !== 1'b0)    begin nerr++; $display("FAIL mid_ignored_dvalid: got %b want 0", dvalid); end
        nvec++; if (overflow !== 1'b0)  begin nerr++; $display("FAIL mid_ignored_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_truncate_and_flush_start();
        int n = 0;
        got.delete();
        nwords = 3;
        tick(1'b1, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 5; i++) tick(1'b0, 1'b1, W'(i), 1'b0);
        nwords = 7;
        tick(1'b1, 1'b0, '0, 1'b0);
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL trunc_flush_done: got %b want 0", done); end
        while (!done && n < 30) begin tick(1'b0, 1'b0, '0, 1'b1); n++; end
        nvec++; if (done !== 1'b1)        begin nerr++; $display("FAIL trunc_done: got %b want 1", done); end
        nvec++; if (words_rcvd !== 32'd3) begin nerr++; $display("FAIL trunc_words_rcvd: got %0d want 3", words_rcvd); end
        nvec++; if (overflow !== 1'b0)    begin nerr++; $display("FAIL trunc_overflow: got %b want 0", overflow); end
        nvec++; if (got.size() != 3)      begin nerr++; $display("FAIL trunc_count: got %0d want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (i >= got.size() || got[i] !== W'(i + 1)) begin
                nerr++; $display("FAIL trunc_word%0d: got %0d want %0d", i, (i < got.size()) ? got[i] : '0, i + 1);
            end
        end
`ifdef COLLECTOR_CHECKSUM_EN
        nvec++; if (checksum !== 32'd6) begin nerr++; $display("FAIL trunc_checksum: got %0d want 6", checksum); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_skid_overflow();
        test_kernel_chain();
        test_zero_words();
        test_reset_mid_frame();
        test_truncate_and_flush_start();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
